req_initiator: RTL
==================

# req_initiator

Requester-side agent for the 4-input request/grant arbiter (`ctrl`). One instance sits on each `req_N` line. It queues burst jobs from local logic and raises `req`. Once granted, it owns the shared resource for the burst length, then releases it. It handles pre-emption (grant withdrawn mid-burst) and grant starvation (timeout).

## Interface
- `LEN_W`, 4: width of the burst-length field. A burst is `job_len+1` beats, so 1..2^LEN_W beats.
- `DEPTH`, 4: job FIFO depth; power of 2, at least 2.
- `TIMEOUT`, 16: consecutive ungranted REQ cycles tolerated before the job is aborted. At least 1.
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-low. All state clears immediately on assertion.
- `job_valid`  in  1  job offered.
- `job_len`  in  LEN_W  burst length minus 1.
- `job_ready`  out  1  FIFO can accept a job. Equals `fifo_count < DEPTH`.
- `req`  out  1  request to the arbiter.
- `gnt`  in  1  grant from the arbiter.
- `busy`  out  1  owns the resource this cycle. Equals `state==OWN`.
- `beat_cnt`  out  LEN_W  beats completed in the current job.
- `done`  out  1  one-cycle pulse: burst completed.
- `timeout_err`  out  1  one-cycle pulse: job aborted, no grant.
- `fifo_count`  out  log2(DEPTH)+1  jobs queued, excluding the active job.

## Operation
- A job is pushed on an edge where `job_valid && job_ready`. `job_ready` depends only on `fifo_count`. A push while full is blocked even if a pop happens on the same edge. Simultaneous push and pop in the non-full case leaves `fifo_count` unchanged.
- FSM states:
  - **IDLE**: if the FIFO is non-empty, pop the head into `len_q`, clear `beat_cnt` and `wait_cnt`, and go to REQ.
  - **REQ**: `req=1`.
    - `gnt=1` at an edge: go to OWN and clear `wait_cnt`.
    - Otherwise `wait_cnt++`. When `wait_cnt` reaches `TIMEOUT`, go to RELEASE with the abort flag set. The job is discarded.
  - **OWN**: `req=1`, `busy=1`.
    - Each edge with `gnt=1` is one beat, so `beat_cnt++`.
    - On the beat where `beat_cnt==len_q`: go to RELEASE with the done flag set.
    - `gnt=0` at an edge (pre-emption): no beat, go to REQ. `beat_cnt` is kept, `wait_cnt` is cleared, and the burst resumes where it stopped.
  - **RELEASE**: `req=0` for exactly one cycle, which is mandatory so the arbiter can rotate. `done` or `timeout_err` is asserted in this cycle per the flag. Then go to IDLE.
- `req` is registered and decoded from state: 1 in REQ and OWN only.
- `beat_cnt` holds its final value through RELEASE and clears on the next pop. It wraps only via the clear.
- `gnt` is ignored in IDLE and RELEASE. A stray grant has no effect.
- Reset mid-burst: the FIFO is flushed and `req` drops asynchronously. No `done` or `timeout_err` is generated.

## Timing
- Reset values: `req=0`, `busy=0`, `done=0`, `timeout_err=0`, `beat_cnt=0`, `fifo_count=0`, `job_ready=1`, state IDLE.
- Push into an empty FIFO on edge E0:
  - `fifo_count=1` after E0.
  - Pop and enter REQ on E1; `req` is high after E1.
  - Minimum push-to-`req` latency is 2 edges.
- Grant latency: `gnt` high at edge Eg gives `busy` high after Eg.
- With `gnt` held high, a job of `job_len=L`:
  - `busy` is high for L+1 cycles.
  - Then one RELEASE cycle with `done=1`, `req=0`.
  - Then IDLE. The next queued job re-raises `req` one cycle later.
- Back-to-back jobs have a `req` low gap of at least 2 cycles (RELEASE + IDLE).
- Timeout: `req` stays high for exactly `TIMEOUT` cycles with `gnt=0`, then one cycle `req=0` with `timeout_err=1`.
- Pre-emption adds 1 REQ cycle minimum. Each pre-emption restarts the timeout window.

## Test plan
- **Reset, then single job**: reset low for 3 cycles, then push `job_len=3` with `gnt` tied to `req` delayed one cycle → `busy` high 4 cycles, `beat_cnt` reaches 3, `done` pulses once, `req` low for 1 cycle.
- **FIFO full**: push 5 jobs back-to-back with `gnt=0`, `DEPTH=4` → the first is popped, `fifo_count` reaches 4, `job_ready=0`, the 6th push is blocked, and all 5 jobs later complete in order with lengths preserved.
- **Starvation**: one job, `gnt` held 0 → `req` high exactly 16 cycles, `timeout_err` pulses, `done` never asserts, FIFO empty afterwards.
- **Pre-emption**: `job_len=7`, drop `gnt` for 2 cycles after beat 3 → `busy` falls, `req` stays high, the burst resumes at `beat_cnt=3`, total busy beats = 8, a single `done`.
- **Reset mid-burst**: assert reset during OWN at beat 2 with 2 jobs queued → `req`, `busy` and `fifo_count` go to 0 asynchronously, and no pulse appears.

Source files
------------

// File: rtl/req_initiator.sv
// req_initiator: requester-side agent for a shared request/grant arbiter.
// Queues burst jobs in a small FIFO, requests the resource, owns it for
// job_len+1 granted beats, then releases it for one mandatory idle cycle.
// Handles grant withdrawal mid-burst (resume) and grant starvation (abort).
//
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous active-low reset; clears all state
//   job_valid    job offered by local logic
//   job_len      burst length minus one
//   job_ready    FIFO can accept a job (fifo_count < DEPTH)
//   req          request to the arbiter (high in REQ and OWN)
//   gnt          grant from the arbiter
//   busy         resource owned this cycle (state OWN)
//   beat_cnt     beats completed in the current job
//   done         one-cycle pulse, burst completed
//   timeout_err  one-cycle pulse, job aborted without grant
//   fifo_count   jobs queued, excluding the active job
module req_initiator #(
    parameter int unsigned LEN_W   = 4,
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     job_valid,
    input  logic [LEN_W-1:0]         job_len,
    output logic                     job_ready,
    output logic                     req,
    input  logic                     gnt,
    output logic                     busy,
    output logic [LEN_W-1:0]         beat_cnt,
    output logic                     done,
    output logic                     timeout_err,
    output logic [$clog2(DEPTH):0]   fifo_count
);

    localparam int unsigned PTR_W  = $clog2(DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;
    localparam int unsigned WAIT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        OWN     = 2'd2,
        RELEASE = 2'd3
    } state_t;

    state_t             state;
    state_t             state_d;

    logic [LEN_W-1:0]   mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   count_d;
    logic               push;
    logic               pop;

    logic [LEN_W-1:0]   len_q;
    logic [LEN_W-1:0]   len_d;
    logic [LEN_W-1:0]   beat_d;
    logic [WAIT_W-1:0]  wait_cnt;
    logic [WAIT_W-1:0]  wait_d;
    logic               done_d;
    logic               tmo_d;

    // Push is qualified by the registered ready so a pop cannot free a slot
    // for a push on the same edge.
    assign push = job_valid && job_ready;

    // FIFO storage; contents are don't-care once the count is flushed.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= job_len;
        end
    end

    // Next-state, counters and pulse decode.
    always_comb begin
        state_d = state;
        pop     = 1'b0;
        len_d   = len_q;
        beat_d  = beat_cnt;
        wait_d  = wait_cnt;
        done_d  = 1'b0;
        tmo_d   = 1'b0;
        unique case (state)
            IDLE: begin
                if (fifo_count != '0) begin
                    pop     = 1'b1;
                    len_d   = mem[rd_ptr];
                    beat_d  = '0;
                    wait_d  = '0;
                    state_d = REQ;
                end
            end
            REQ: begin
                if (gnt) begin
                    wait_d  = '0;
                    state_d = OWN;
                end else begin
                    wait_d = wait_cnt + WAIT_W'(1);
                    if (wait_cnt == WAIT_W'(TIMEOUT - 1)) begin
                        tmo_d   = 1'b1;
                        state_d = RELEASE;
                    end
                end
            end
            OWN: begin
                if (gnt) begin
                    // Final beat leaves beat_cnt at len_q so it never wraps.
                    if (beat_cnt == len_q) begin
                        done_d  = 1'b1;
                        state_d = RELEASE;
                    end else begin
                        beat_d = beat_cnt + LEN_W'(1);
                    end
                end else begin
                    // Pre-empted: keep progress, restart the starvation window.
                    wait_d  = '0;
                    state_d = REQ;
                end
            end
            RELEASE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        count_d = fifo_count + CNT_W'(push) - CNT_W'(pop);
    end

    // State, FIFO bookkeeping and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            fifo_count  <= '0;
            job_ready   <= 1'b1;
            len_q       <= '0;
            beat_cnt    <= '0;
            wait_cnt    <= '0;
            req         <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            state       <= state_d;
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            fifo_count  <= count_d;
            job_ready   <= (count_d != CNT_W'(DEPTH));
            len_q       <= len_d;
            beat_cnt    <= beat_d;
            wait_cnt    <= wait_d;
            req         <= (state_d == REQ) || (state_d == OWN);
            busy        <= (state_d == OWN);
            done        <= done_d;
            timeout_err <= tmo_d;
        end
    end

endmodule
